calc_cmd_sequencer: RTL and testbench

//  Upstream command feeder for the synchronous accumulator calculator.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_cmd_fifo.sv | 57 +++++
 rtl/calc_cmd_sequencer.sv | 109 ++++++++++
 tb/tb_calc_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcode encoding and helpers for the calculator command path.
// No logic of its own; constants and a pure function only.
// Not applicable: nothing here carries flow control.
package calc_pkg;

  localparam int DATA_W = 8;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_LOAD = 3'b000;
  localparam opcode_t OP_ADD  = 3'b001;
  localparam opcode_t OP_SUB  = 3'b010;
  localparam opcode_t OP_READ = 3'b011;
  localparam opcode_t OP_NOP  = 3'b111;

  // LOAD/PASS and READ drive a value onto saida; everything else leaves it at 0.
  function automatic logic is_result_op(input opcode_t code);
    return (code == OP_LOAD) || (code == OP_READ);
  endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO; head word visible combinationally from storage.
// Latency: a pushed word is at the head one cycle after the push edge.
// Backpressure: full/empty gate push/pop internally; clear flushes on the next edge.
module calc_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra wrap bit distinguishes full (same index, different lap) from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer advance; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Feeds buffered opcode/operand commands to the accumulator calculator and captures its results.
// Latency: push to issue 1 cycle; issue of a result op to res_valid 2 cycles.
// Backpressure: cmd_ready = !full; a result op stalls at the head while a capture is in flight or res is unconsumed.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = calc_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_code,
  input  logic [DATA_W-1:0]       cmd_data,
  output logic [2:0]              calc_codigo,
  output logic [DATA_W-1:0]       calc_entrada,
  input  logic [DATA_W-1:0]       calc_saida,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic [$clog2(DEPTH):0]  fill_level
);

  localparam int CMD_W = 3 + DATA_W;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CMD_W-1:0]  head;
  opcode_t           head_code;
  logic [DATA_W-1:0] head_data;
  logic              head_is_res;
  logic              push;
  logic              issue;
  logic              pend1;
  logic              pend2;

  assign head_code   = head[CMD_W-1:DATA_W];
  assign head_data   = head[DATA_W-1:0];
  assign head_is_res = is_result_op(head_code);

  // Ready depends only on stored state, never on cmd_valid; pushes during clear are dropped.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full && !clear;

  // A result op may only go when the capture pipe is idle and the result slot is
  // free by the time its value lands, so a capture never collides with a held result.
  assign issue = !fifo_empty && !clear &&
                 (!head_is_res || (!(pend1 || pend2) && (!res_valid || res_ready)));

  calc_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data ({cmd_code, cmd_data}),
    .pop       (issue),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fill_level)
  );

  // Issue register: present the popped command for one cycle, otherwise NOP with zero operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_codigo  <= OP_NOP;
      calc_entrada <= '0;
    end else if (issue) begin
      calc_codigo  <= head_code;
      calc_entrada <= head_data;
    end else begin
      calc_codigo  <= OP_NOP;
      calc_entrada <= '0;
    end
  end

  // Capture pipeline: pend1 while the calculator computes saida, pend2 while it is on saida.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      pend1 <= issue && head_is_res;
      pend2 <= pend1 && !clear;
    end
  end

  // Result register: load from saida when pend2 matures, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (clear) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (pend2) begin
      res_valid <= 1'b1;
      res_data  <= calc_saida;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with a behavioural accumulator calculator attached.
// Inputs change and outputs are sampled on the falling edge.
// Results are logged by a monitor on each res handshake.
module tb_calc_cmd_sequencer;
  import calc_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_code;
  logic [DW-1:0] cmd_data;
  logic [2:0]    calc_codigo;
  logic [DW-1:0] calc_entrada;
  logic [DW-1:0] calc_saida;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [LW-1:0] fill_level;

  logic [DW-1:0] acc;
  int            n_pass  = 0;
  int            n_total = 0;
  int            cyc     = 0;
  logic [DW-1:0] got[$];
  int            got_cyc[$];

  always #5 clk = ~clk;

  calc_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .cmd_data     (cmd_data),
    .calc_codigo  (calc_codigo),
    .calc_entrada (calc_entrada),
    .calc_saida   (calc_saida),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .fill_level   (fill_level)
  );

  // Calculator: PASS copies entrada to saida, ADD/SUB update acc, READ shows acc, else saida 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      calc_saida <= '0;
    end else begin
      case (calc_codigo)
        3'b000:  calc_saida <= calc_entrada;
        3'b001:  begin acc <= acc + calc_entrada; calc_saida <= '0; end
        3'b010:  begin acc <= acc - calc_entrada; calc_saida <= '0; end
        3'b011:  calc_saida <= acc;
        default: calc_saida <= '0;
      endcase
    end
  end

  // Log every completed result handshake with its cycle number.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && res_valid && res_ready) begin
      got.push_back(res_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
  endtask

  task automatic push(input logic [2:0] code, input logic [DW-1:0] data);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, got.size(), n);
  endtask

  // Leaves the FIFO holding 4 READs with a freshly issued READ in flight (acc must be 4).
  task automatic prefill(input string tag);
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(OP_READ, 8'h00);
    check({tag, "_held_valid"}, res_valid, 1);
    check({tag, "_held_data"}, res_data, 8'h04);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_half_full"}, fill_level, 4);
    check({tag, "_inflight"}, calc_codigo, 3'b011);
  endtask

  initial begin
    int base;
    int bad;
    int hits;
    rst_n     = 1'b0;
    clear     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 3'b000;
    cmd_data  = '0;
    res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_fill", fill_level, 0);
    check("rst_codigo", calc_codigo, 3'b111);
    check("rst_entrada", calc_entrada, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 0x2A: issue one cycle after push, result two cycles after issue
    res_ready = 1'b1;
    push(OP_LOAD, 8'h2A);
    check("load_fill", fill_level, 1);
    check("load_not_yet", calc_codigo, 3'b111);
    @(negedge clk);
    check("load_codigo", calc_codigo, 3'b000);
    check("load_entrada", calc_entrada, 8'h2A);
    check("load_fill_drained", fill_level, 0);
    @(negedge clk);
    check("load_res_early", res_valid, 0);
    @(negedge clk);
    check("load_res_valid", res_valid, 1);
    check("load_res_data", res_data, 8'h2A);
    wait_results(1, 10, "load_count");

    // Arithmetic and wrap
    push(OP_ADD, 8'd5);
    push(OP_ADD, 8'd7);
    push(OP_SUB, 8'd2);
    push(OP_READ, 8'h00);
    wait_results(2, 20, "arith_count");
    if (got.size() >= 2) check("arith_value", got[1], 8'h0A);
    push(OP_ADD, 8'hFF);
    push(OP_ADD, 8'hFF);
    push(OP_READ, 8'h00);
    wait_results(3, 20, "wrap_count");
    if (got.size() >= 3) check("wrap_value", got[2], 8'h08);

    // Backpressure: nine READs with the consumer stalled
    res_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 9; i++) push(OP_READ, 8'h00);
    check("full_fill", fill_level, 8);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_res_valid", res_valid, 1);
    check("full_res_data", res_data, 8'h08);
    push(OP_ADD, 8'h55);
    @(negedge clk);
    check("full_no_overflow", fill_level, 8);
    check("full_held_data", res_data, 8'h08);
    check("full_held_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_results(base + 9, 80, "drain_count");
    bad = 0;
    for (int i = base; i < got.size(); i++) if (got[i] !== 8'h08) bad++;
    check("drain_values_bad", bad, 0);
    bad = 0;
    for (int i = base + 1; i < got.size(); i++) if (got_cyc[i] - got_cyc[i-1] != 3) bad++;
    check("drain_spacing_bad", bad, 0);
    check("drain_fill", fill_level, 0);

    // READ, ADD 1, READ from acc=3: ADD slips in right after the first READ
    base = got.size();
    push(OP_SUB, 8'd5);
    push(OP_READ, 8'h00);
    check("b2b_sub_issued", calc_codigo, 3'b010);
    push(OP_ADD, 8'd1);
    check("b2b_read1_issued", calc_codigo, 3'b011);
    push(OP_READ, 8'h00);
    check("b2b_add_issued", calc_codigo, 3'b001);
    @(negedge clk);
    check("b2b_read2_stall", calc_codigo, 3'b111);
    @(negedge clk);
    check("b2b_read2_issued", calc_codigo, 3'b011);
    wait_results(base + 2, 20, "b2b_count");
    if (got.size() >= base + 2) begin
      check("b2b_first", got[base], 8'h03);
      check("b2b_second", got[base+1], 8'h04);
    end

    // clear with FIFO half full and a result in flight; simultaneous push dropped
    prefill("clr");
    base      = got.size();
    clear     = 1'b1;
    cmd_valid = 1'b1;
    cmd_code  = OP_READ;
    @(negedge clk);
    clear     = 1'b0;
    cmd_valid = 1'b0;
    check("clr_fill", fill_level, 0);
    check("clr_res_valid", res_valid, 0);
    check("clr_codigo", calc_codigo, 3'b111);
    res_ready = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid || fill_level != 0 || calc_codigo != 3'b111) hits++;
    end
    check("clr_quiet_after", hits, 0);
    check("clr_no_stale", got.size(), base);

    // async reset with the same in-flight state
    prefill("arst");
    base  = got.size();
    rst_n = 1'b0;
    #1;
    check("arst_fill", fill_level, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_codigo", calc_codigo, 3'b111);
    check("arst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid || fill_level != 0 || calc_codigo != 3'b111) hits++;
    end
    check("arst_quiet_after", hits, 0);
    check("arst_no_stale", got.size(), base);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
